// File: rtl/prio_scan_display_if.sv
// prio_scan_display_if: pin-side inputs and display/encoder outputs of prio_scan_display
interface prio_scan_display_if #(
  parameter int N_IN = 8
);
  logic [N_IN-1:0] in_raw;
  logic msb_first;
  logic hold;
  logic valid;
  logic [7:0] index;
  logic [7:0] count;
  logic [3:0] dig;
  logic [6:0] seg;
  logic colon;
  modport master (
    output in_raw, msb_first, hold,
    input valid, index, count, dig, seg, colon
  );
  modport slave (
    input in_raw, msb_first, hold,
    output valid, index, count, dig, seg, colon
  );
endinterface

// File: rtl/prio_scan_display.sv
// prio_scan_display: debounced priority encoder with popcount on a 4-digit multiplexed hex display
module prio_scan_display #(
  parameter int N_IN = 8,
  parameter int STABLE_CYCLES = 50000,
  parameter int REFRESH_DIV = 50000
) (
  input logic clk,
  input logic rst_n,
  prio_scan_display_if.slave bus
);
  localparam int sw = $clog2(STABLE_CYCLES) + 1;
  localparam int rw = $clog2(REFRESH_DIV);
  localparam logic [111:0] font_rom = {
    7'b0111000, 7'b0110000, 7'b1000010, 7'b0110001,
    7'b1100000, 7'b0001000, 7'b0000100, 7'b0000000,
    7'b0001111, 7'b0100000, 7'b0100100, 7'b1001100,
    7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
  };
  logic [N_IN-1:0] s1, s2, cand, acc;
  logic [sw-1:0] stab_cnt;
  logic [rw-1:0] rc;
  logic [1:0] ptr, nptr;
  logic [3:0] dig_q;
  logic [6:0] seg_q, seg_n, font_base;
  logic [7:0] idx, cnt;
  logic [15:0] word;
  logic [3:0] nib;
  logic wrap;
  // synchronise the raw lines, track the candidate and accept it once stable long enough
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      cand <= '0;
      acc <= '0;
      stab_cnt <= '0;
    end else begin
      s1 <= bus.in_raw;
      s2 <= s1;
      if (s2 != cand) begin
        cand <= s2;
        stab_cnt <= '0;
      end else if (stab_cnt != sw'(STABLE_CYCLES - 1)) begin
        stab_cnt <= stab_cnt + 1'b1;
      end else if (!bus.hold) begin
        acc <= cand;
      end
    end
  end
  // popcount and winning index; the later loop overrides so the right end wins per direction
  always_comb begin
    cnt = '0;
    idx = '0;
    for (int i = 0; i < N_IN; i++) begin
      cnt = cnt + 8'(acc[i]);
      if (bus.msb_first && acc[i]) idx = 8'(i);
    end
    for (int i = N_IN - 1; i >= 0; i--) begin
      if (!bus.msb_first && acc[i]) idx = 8'(i);
    end
  end
  // pick the nibble for the digit about to be lit so dig and seg move together
  always_comb begin
    wrap = rc == rw'(REFRESH_DIV - 1);
    nptr = ptr + 2'(wrap);
    word = {cnt, idx};
    nib = word[{nptr, 2'b00} +: 4];
    font_base = 7'(nib) * 7'd7;
    seg_n = (|acc) ? font_rom[font_base +: 7] : 7'h7f;
  end
  // refresh timer, digit pointer and registered display drive
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rc <= '0;
      ptr <= '0;
      dig_q <= 4'b0001;
      seg_q <= 7'h7f;
    end else begin
      rc <= wrap ? '0 : rc + 1'b1;
      ptr <= nptr;
      dig_q <= 4'b0001 << nptr;
      seg_q <= seg_n;
    end
  end
  assign bus.valid = |acc;
  assign bus.index = idx;
  assign bus.count = cnt;
  assign bus.dig = dig_q;
  assign bus.seg = seg_q;
  assign bus.colon = 1'b1;
endmodule

// File: tb/tb_prio_scan_display.sv
// tb_prio_scan_display: randomized and directed checks against a window-based reference model
module tb_prio_scan_display;
  localparam int N = 16;
  localparam int S = 3;
  localparam int R = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int passed = 0;
  int total = 0;
  logic [15:0] raw_q[$];
  logic [15:0] win_q[$];
  logic [15:0] acc_m = '0;
  int e_m = 0;
  logic [6:0] seg_m = 7'h7f;
  logic [3:0] dig_m = 4'b0001;
  logic [6:0] font_m [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };
  prio_scan_display_if #(.N_IN(N)) bus();
  prio_scan_display #(.N_IN(N), .STABLE_CYCLES(S), .REFRESH_DIV(R)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic int idx_of(input logic [15:0] v, input logic msb);
    if (msb) begin
      for (int i = N - 1; i >= 0; i--) if (v[i]) return i;
    end else begin
      for (int i = 0; i < N; i++) if (v[i]) return i;
    end
    return 0;
  endfunction
  task automatic tick();
    logic [15:0] s2v;
    logic [15:0] w;
    int p;
    bit same;
    @(posedge clk);
    if (!rst_n) begin
      raw_q = '{16'h0, 16'h0};
      win_q = '{16'h0};
      acc_m = '0;
      e_m = 0;
      seg_m = 7'h7f;
    end else begin
      e_m++;
      p = (e_m / R) % 4;
      w = {8'($countones(acc_m)), 8'(idx_of(acc_m, bus.msb_first))};
      seg_m = (acc_m != 0) ? font_m[(w >> (4 * p)) & 16'hf] : 7'h7f;
      s2v = raw_q.pop_front();
      raw_q.push_back(bus.in_raw);
      win_q.push_back(s2v);
      if (win_q.size() > S + 1) void'(win_q.pop_front());
      same = win_q.size() == S + 1;
      foreach (win_q[i]) if (win_q[i] != s2v) same = 0;
      if (same && !bus.hold) acc_m = s2v;
    end
    dig_m = 4'b0001 << ((e_m / R) % 4);
    #1;
    check("valid", int'(bus.valid), int'(acc_m != 0));
    check("index", int'(bus.index), idx_of(acc_m, bus.msb_first));
    check("count", int'(bus.count), $countones(acc_m));
    check("dig", int'(bus.dig), int'(dig_m));
    check("seg", int'(bus.seg), int'(seg_m));
    check("colon", int'(bus.colon), 1);
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  initial begin
    raw_q = '{16'h0, 16'h0};
    win_q = '{16'h0};
    bus.in_raw = '0;
    bus.msb_first = 1'b1;
    bus.hold = 1'b0;
    run(2);
    check("rst_dig", int'(bus.dig), 1);
    check("rst_seg", int'(bus.seg), 'h7f);
    check("rst_valid", int'(bus.valid), 0);
    rst_n = 1'b1;
    bus.in_raw = 16'h0024;
    run(5);
    check("acc_early", int'(bus.valid), 0);
    tick();
    check("acc_idx_msb", int'(bus.index), 5);
    check("acc_cnt", int'(bus.count), 2);
    bus.msb_first = 1'b0;
    #1;
    check("acc_idx_lsb", int'(bus.index), 2);
    run(4);
    bus.msb_first = 1'b1;
    bus.in_raw = 16'h8000;
    run(2);
    bus.in_raw = 16'h0024;
    run(10);
    check("glitch_idx", int'(bus.index), 5);
    bus.in_raw = 16'h8000;
    run(8);
    check("pulse_idx", int'(bus.index), 15);
    check("pulse_cnt", int'(bus.count), 1);
    bus.in_raw = 16'hffff;
    run(24);
    check("full_cnt", int'(bus.count), 16);
    bus.hold = 1'b1;
    bus.in_raw = 16'h0001;
    run(8);
    check("hold_frz", int'(bus.count), 16);
    bus.hold = 1'b0;
    tick();
    check("hold_rel", int'(bus.count), 1);
    check("hold_rel_idx", int'(bus.index), 0);
    bus.in_raw = 16'habcd;
    run(3);
    rst_n = 1'b0;
    bus.in_raw = '0;
    tick();
    rst_n = 1'b1;
    run(10);
    check("rst_mid_valid", int'(bus.valid), 0);
    bus.in_raw = 16'h0300;
    run(8);
    bus.in_raw = '0;
    run(6);
    for (int i = 0; i < 16; i++) begin
      tick();
      check("blank_seg", int'(bus.seg), 'h7f);
    end
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(5) == 0) bus.in_raw = 16'($urandom);
      if ($urandom_range(7) == 0) bus.msb_first = ~bus.msb_first;
      if ($urandom_range(9) == 0) bus.hold = ~bus.hold;
      rst_n = $urandom_range(99) != 0;
      tick();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
